demux1to16_capture: RTL
=======================

# demux1to16_capture

Serial-to-parallel 1-to-16 demultiplexer. It writes a single input bit into one of 16 output register positions, either at an explicitly supplied 4-bit select (direct mode) or at an internally incremented select (sequential capture mode). It sits on the far side of the 16:1 mux datapath: a word that is scanned out bit-by-bit through the mux is rebuilt here into a 16-bit word.

## Interface
- WIDTH, 16: output word width; fixed at 2**SEL_W.
- SEL_W, 4: select width.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bit  input  1  data bit to route.
- sel  input  SEL_W  target bit position in direct mode; ignored in sequential mode.
- wr_en  input  1  direct-mode write strobe.
- start  input  1  begins a sequential capture.
- in_valid  input  1  in_bit is valid this cycle during a capture.
- out  output  WIDTH  assembled word register.
- en  output  WIDTH  registered one-hot marker of the position written on the previous edge; all-zero otherwise.
- word_valid  output  1  one-cycle pulse after a full 16-bit capture completes.
- busy  output  1  high while in CAPTURE.

## Operation
- Reset values: out=16'h0000, en=0, word_valid=0, busy=0, state=IDLE, cnt=0, shadow=0.
- States and transitions:
  - IDLE -> CAPTURE on start. This clears cnt and shadow.
  - CAPTURE -> IDLE on the edge that accepts bit 15.
  - CAPTURE -> CAPTURE on start. This restarts the capture: cnt=0, shadow=0, and any partial word is discarded.
- Direct mode, IDLE only, when wr_en=1 and start=0:
  - out[sel] <= in_bit.
  - en <= 1<<sel.
  - All other bits of out hold their value.
- wr_en is ignored in CAPTURE.
- When start and wr_en are both high in IDLE, start wins and no direct write occurs.
- Sequential mode, CAPTURE, when in_valid=1:
  - shadow[cnt] <= in_bit.
  - en <= 1<<cnt.
  - cnt <= cnt+1, wrapping from 15 to 0.
  - Bit order is LSB first: the first accepted bit lands in bit 0.
- in_valid=0 in CAPTURE: a stall. cnt and shadow hold, and en=0.
- Completion, on the edge that accepts bit 15:
  - out <= {in_bit, shadow[14:0]}. The whole word updates atomically.
  - word_valid <= 1.
  - state <= IDLE.
- out does not change during a capture until completion; intermediate bits exist only in shadow.
- A start in the cycle after completion, while word_valid is still high, is accepted normally.

## Timing
- Direct write: out and en reflect the write one clock after the wr_en edge. Latency is 1 cycle.
- Capture: start accepted at edge E0, so busy=1 from E0.
  - With no stalls, the 16 bits are accepted at edges E1..E16. in_valid is sampled from the cycle after start.
  - At E16: out updates, word_valid=1 for exactly the cycle E16..E17, and busy=0.
  - Minimum start-to-word_valid is 16 cycles. Each in_valid=0 cycle adds exactly 1 cycle.
- en and word_valid are registered outputs and stay high for a single cycle only.
- busy is registered: high from the edge that accepts start to the edge that accepts bit 15.
- Reset mid-capture (asynchronous rst_n low at any point): all outputs go immediately to their reset values. After release, the block is in IDLE and no word_valid is emitted for the aborted capture.

## Test plan
- Reset: assert rst_n=0 with random inputs -> out=0000, en=0, word_valid=0, busy=0 asynchronously, with no clock edge needed.
- Direct writes: from reset, apply (sel=b, in_bit=1), then (sel=0, 1), then (sel=f, 1), then (sel=0, 0).
  - Required out sequence: 0800, 0801, 8801, 8800.
  - Required en sequence: 0800, 0001, 8000, 0001.
- Sequential capture: pulse start, then drive the 16 bits of 16'h3f0d LSB first with in_valid=1 continuously.
  - word_valid must pulse once, 16 cycles after the start edge, with out=3f0d.
  - out must stay at its previous value throughout the capture.
  - en must step 0001, 0002, ... 8000.
- Stalls: repeat the 16'h3f0d capture with in_valid=0 on every third cycle -> out=3f0d, and word_valid arrives 16 + (number of stall cycles) cycles after start.
- Restart and mode conflict:
  - Restart: begin capturing 16'hffff; after 7 bits, pulse start, then capture 16'h00a5 -> a single word_valid pulse with out=00a5.
  - Direct write during CAPTURE: wr_en=1, sel=3 -> out unchanged.
- Reset mid-capture: after 10 bits, drop rst_n for 1 cycle; then capture 16'h1234 -> out=0000 immediately after reset, no word_valid for the aborted capture, then out=1234 with one word_valid pulse.

Source files
------------

// File: rtl/demux1to16_capture.sv
// demux1to16_capture
// Rebuilds a 16-bit word from a serial bit stream, or writes single bits directly.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   in_bit       : data bit to route
//   sel          : target bit position for direct writes (ignored while capturing)
//   wr_en        : direct-write strobe, honoured only in IDLE without start
//   start        : begins (or restarts) a sequential LSB-first capture
//   in_valid     : in_bit is valid this cycle during a capture
//   out          : assembled word register
//   en           : one-hot marker of the position written on the previous edge
//   word_valid   : one-cycle pulse after a full capture completes
//   busy         : high while capturing
module demux1to16_capture #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned WIDTH = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] sel,
  input  logic             wr_en,
  input  logic             start,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] en,
  output logic             word_valid,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StCapture} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   en_q, en_d;
  logic               word_valid_q, word_valid_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    out_d        = out_q;
    en_d         = '0;
    word_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // start has priority over a simultaneous direct write
        if (start) begin
          state_d  = StCapture;
          cnt_d    = '0;
          shadow_d = '0;
        end else if (wr_en) begin
          out_d[sel] = in_bit;
          en_d       = WIDTH'(1) << sel;
        end
      end
      StCapture: begin
        if (start) begin
          // Restart: discard the partial word
          cnt_d    = '0;
          shadow_d = '0;
        end else if (in_valid) begin
          shadow_d[cnt_q] = in_bit;
          en_d            = WIDTH'(1) << cnt_q;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == SEL_W'(WIDTH - 1)) begin
            // Final bit bypasses shadow so out updates as one whole word
            out_d        = {in_bit, shadow_q[WIDTH-2:0]};
            word_valid_d = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shadow_q     <= '0;
      out_q        <= '0;
      en_q         <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      out_q        <= out_d;
      en_q         <= en_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign out        = out_q;
  assign en         = en_q;
  assign word_valid = word_valid_q;
  assign busy       = (state_q == StCapture);

endmodule
